mole_hit_scorer: RTL

Parametrised hit-detection and scoring engine for the whack-a-mole game. It sits between the mole generator, the keyboard scanner, the timer and the central game FSM. It tracks up to MOLES simultaneously live moles on a ROWS x COLS grid and scores each mole at most once. It keeps a multi-digit BCD score with an optional miss penalty, and produces the win and timeout indications consumed by the FSM.

---
 rtl/mole_hit_scorer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/mole_hit_scorer.sv
// Hit detection and BCD scoring for whack-a-mole: MOLES live slots, one score per mole,
// saturating BCD score with optional miss penalty, registered win/timeout flags.
module mole_hit_scorer #(
  parameter int ROW_W     = 3,
  parameter int COL_W     = 3,
  parameter int MOLES     = 2,
  parameter int DIGITS    = 2,
  parameter int WIN_SCORE = 10,
  parameter int PENALTY   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     game_en,
  input  logic                     clear,
  input  logic [MOLES-1:0]         spawn,
  input  logic [MOLES*ROW_W-1:0]   spawn_row,
  input  logic [MOLES*COL_W-1:0]   spawn_col,
  input  logic                     key_valid,
  input  logic [ROW_W-1:0]         key_row,
  input  logic [COL_W-1:0]         key_col,
  input  logic                     time_zero,
  output logic                     hit,
  output logic [2:0]               hit_slot,
  output logic                     miss,
  output logic [MOLES-1:0]         alive,
  output logic [4*DIGITS-1:0]      score,
  output logic [7:0]               miss_cnt,
  output logic                     win,
  output logic                     timeout
);

  localparam logic [15:0] WIN_BIN = 16'(WIN_SCORE);

  function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    logic                c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c && (v[4*i +: 4] == 4'd9)) begin
        r[4*i +: 4] = 4'd0;
      end else if (c) begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd1;
        c = 1'b0;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    // A carry out of the top digit means the score was all 9s: hold it.
    return c ? v : r;
  endfunction

  function automatic logic [4*DIGITS-1:0] bcd_dec(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    logic                b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b && (v[4*i +: 4] == 4'd0)) begin
        r[4*i +: 4] = 4'd9;
      end else if (b) begin
        r[4*i +: 4] = v[4*i +: 4] - 4'd1;
        b = 1'b0;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return b ? v : r;
  endfunction

  function automatic logic [15:0] bcd_to_bin(input logic [4*DIGITS-1:0] v);
    logic [15:0] acc;
    acc = 16'd0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc = (acc * 16'd10) + {12'd0, v[4*i +: 4]};
    end
    return acc;
  endfunction

  logic [ROW_W-1:0]    r_row [MOLES];
  logic [COL_W-1:0]    r_col [MOLES];
  logic [MOLES-1:0]    r_alive;
  logic                r_hit;
  logic [2:0]          r_hit_slot;
  logic                r_miss;
  logic [4*DIGITS-1:0] r_score;
  logic [7:0]          r_miss_cnt;
  logic                r_win;
  logic                r_timeout;

  logic                w_press;
  logic [MOLES-1:0]    w_match;
  logic [MOLES-1:0]    w_hit_mask;
  logic                w_any;
  logic [2:0]          w_idx;
  logic [MOLES-1:0]    w_alive_nxt;
  logic [4*DIGITS-1:0] w_score_nxt;

  assign w_press = key_valid && game_en && !clear;

  // Compare the press against every live slot; keep only the lowest matching index.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < MOLES; i++) begin
      w_match[i] = r_alive[i] && (r_row[i] == key_row) && (r_col[i] == key_col);
    end
    w_hit_mask = w_match & (~w_match + MOLES'(1));
    w_any      = |w_match;
    w_idx      = 3'd0;
    for (int i = 0; i < MOLES; i++) begin
      if (w_hit_mask[i]) begin
        w_idx = 3'(i);
      end else begin
        w_idx = w_idx;
      end
    end
  end

  // Next alive vector and score; a same-cycle spawn overrides the hit-clear.
  always_comb begin
    w_alive_nxt = r_alive;
    w_score_nxt = r_score;
    if (w_press && w_any) begin
      w_alive_nxt = r_alive & ~w_hit_mask;
      w_score_nxt = bcd_inc(r_score);
    end else if (w_press && (PENALTY != 0)) begin
      w_score_nxt = bcd_dec(r_score);
    end else begin
      w_score_nxt = r_score;
    end
    w_alive_nxt = w_alive_nxt | spawn;
  end

  // Slot coordinate storage, loaded on spawn.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MOLES; i++) begin
        r_row[i] <= '0;
        r_col[i] <= '0;
      end
    end else if (!clear) begin
      for (int i = 0; i < MOLES; i++) begin
        if (spawn[i]) begin
          r_row[i] <= spawn_row[i*ROW_W +: ROW_W];
          r_col[i] <= spawn_col[i*COL_W +: COL_W];
        end
      end
    end
  end

  // Scoring state, hit/miss pulses and registered flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alive    <= '0;
      r_hit      <= 1'b0;
      r_hit_slot <= 3'd0;
      r_miss     <= 1'b0;
      r_score    <= '0;
      r_miss_cnt <= 8'd0;
      r_win      <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= time_zero;
      if (clear) begin
        r_alive    <= '0;
        r_hit      <= 1'b0;
        r_hit_slot <= 3'd0;
        r_miss     <= 1'b0;
        r_score    <= '0;
        r_miss_cnt <= 8'd0;
        r_win      <= 1'b0;
      end else begin
        r_alive <= w_alive_nxt;
        r_score <= w_score_nxt;
        r_hit   <= w_press && w_any;
        r_miss  <= w_press && !w_any;
        // win trails the score register by one edge.
        r_win   <= (bcd_to_bin(r_score) >= WIN_BIN);
        if (w_press && w_any) begin
          r_hit_slot <= w_idx;
        end
        if (w_press && !w_any && (r_miss_cnt != 8'hFF)) begin
          r_miss_cnt <= r_miss_cnt + 8'd1;
        end
      end
    end
  end

  assign hit      = r_hit;
  assign hit_slot = r_hit_slot;
  assign miss     = r_miss;
  assign alive    = r_alive;
  assign score    = r_score;
  assign miss_cnt = r_miss_cnt;
  assign win      = r_win;
  assign timeout  = r_timeout;

endmodule
